// File: rtl/clk_div_pkg.sv
// Shared constants and config clamp helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned MIN_DIV  = 2;
    localparam int unsigned MIN_HIGH = 1;

    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < MIN_DIV) ? MIN_DIV : n;
    endfunction

    // n must already be a clamped divisor, so the result always fits its width
    function automatic logic [31:0] clamp_high(input logic [31:0] h, input logic [31:0] n);
        logic [31:0] c;
        c = (h < MIN_HIGH) ? MIN_HIGH : h;
        if (c >= n) c = n - 32'd1;
        return c;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
// duty50 exists only when CLK_DIV_DUTY50_EN is defined.
interface clk_div_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div_val;
    logic [WIDTH-1:0] high_val;
    logic             load_ack;
    logic             tick;
    logic             outclk;
`ifdef CLK_DIV_DUTY50_EN
    logic             duty50;
`endif

    modport master (
        output en, load, div_val, high_val,
`ifdef CLK_DIV_DUTY50_EN
        output duty50,
`endif
        input  load_ack, tick, outclk
    );

    modport slave (
        input  en, load, div_val, high_val,
`ifdef CLK_DIV_DUTY50_EN
        input  duty50,
`endif
        output load_ack, tick, outclk
    );
endinterface

// File: rtl/clk_div_cfg.sv
// Pending/active divisor and high-time registers with clamping and load_ack.
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEF_DIV  = 5,
    parameter int DEF_HIGH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_wrap,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_div_val,
    input  logic [WIDTH-1:0] i_high_val,
    output logic [WIDTH-1:0] o_div,
    output logic [WIDTH-1:0] o_high,
    output logic             o_load_ack
);

    logic [WIDTH-1:0] w_div_c;
    logic [WIDTH-1:0] w_high_c;
    logic             w_apply;
    logic [WIDTH-1:0] r_pend_div;
    logic [WIDTH-1:0] r_pend_high;
    logic             r_pend;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_high;
    logic             r_ack;

    assign w_div_c  = WIDTH'(clamp_div(32'(i_div_val)));
    assign w_high_c = WIDTH'(clamp_high(32'(i_high_val), 32'(w_div_c)));

    // A stopped divider has no boundary to wait for, so apply straight away
    assign w_apply = r_pend && (i_wrap || !i_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_div  <= WIDTH'(DEF_DIV);
            r_pend_high <= WIDTH'(DEF_HIGH);
            r_pend      <= 1'b0;
            r_div       <= WIDTH'(DEF_DIV);
            r_high      <= WIDTH'(DEF_HIGH);
            r_ack       <= 1'b0;
        end else begin
            r_ack <= w_apply;
            if (w_apply) begin
                r_div  <= r_pend_div;
                r_high <= r_pend_high;
            end
            // A load coinciding with an apply stays pending for the next boundary
            if (i_load) begin
                r_pend_div  <= w_div_c;
                r_pend_high <= w_high_c;
                r_pend      <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_div      = r_div;
    assign o_high     = r_high;
    assign o_load_ack = r_ack;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: period counter and registered output stage.
// Define CLK_DIV_DUTY50_EN to add the duty50 input and the odd-N half-cycle stretch.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEF_DIV  = 5,
    parameter int DEF_HIGH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    clk_div_prog_if.slave bus
);

    localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_div;
    logic [WIDTH-1:0] w_high;
    logic [WIDTH-1:0] w_thr;
    logic             w_wrap;
    logic             w_load_ack;
    logic [WIDTH-1:0] r_cnt;
    logic             r_outclk;
    logic             r_tick;

    clk_div_cfg #(
        .WIDTH   (WIDTH),
        .DEF_DIV (DEF_DIV),
        .DEF_HIGH(DEF_HIGH)
    ) u_cfg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (bus.en),
        .i_wrap    (w_wrap),
        .i_load    (bus.load),
        .i_div_val (bus.div_val),
        .i_high_val(bus.high_val),
        .o_div     (w_div),
        .o_high    (w_high),
        .o_load_ack(w_load_ack)
    );

    assign w_wrap = bus.en && (r_cnt == (w_div - W_ONE));

`ifdef CLK_DIV_DUTY50_EN
    assign w_thr = bus.duty50 ? (w_div >> 1) : w_high;
`else
    assign w_thr = w_high;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_outclk <= 1'b0;
            r_tick   <= 1'b0;
        end else if (!bus.en) begin
            r_cnt    <= '0;
            r_outclk <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_cnt    <= w_wrap ? '0 : (r_cnt + W_ONE);
            r_outclk <= (r_cnt < w_thr);
            r_tick   <= (r_cnt == '0);
        end
    end

`ifdef CLK_DIV_DUTY50_EN
    logic r_half_en;
    logic r_outclk_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_half_en <= 1'b0;
        else        r_half_en <= bus.en && bus.duty50 && w_div[0];
    end

    // Half-cycle-late copy; ORed in, it stretches the odd-N high pulse by half a clk
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) r_outclk_dly <= 1'b0;
        else        r_outclk_dly <= r_outclk && r_half_en;
    end

    assign bus.outclk = r_outclk | r_outclk_dly;
`else
    assign bus.outclk = r_outclk;
`endif

    assign bus.tick     = r_tick;
    assign bus.load_ack = w_load_ack;

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL take parameter WIDTH, default 8, meaning bit width of counter, divisor and high-time fields.
REQ-002 SHALL take parameter DEF_DIV, default 5, meaning divisor in force after reset.
REQ-003 SHALL take parameter DEF_HIGH, default 2, meaning high-time in clk cycles in force after reset.
REQ-004 SHALL provide port clk, input, 1, meaning clock; all logic SHALL be rising-edge, except the REQ-025 flop.
REQ-005 SHALL provide port rst_n, input, 1, meaning reset: asynchronous, active-low.
REQ-006 SHALL provide port en, input, 1, meaning divider run enable.
REQ-007 SHALL provide port load, input, 1, meaning a one-cycle request to take div_val/high_val.
REQ-008 SHALL provide port div_val, input, WIDTH, meaning requested divisor N.
REQ-009 SHALL provide port high_val, input, WIDTH, meaning requested high-time H in clk cycles.
REQ-010 SHALL provide port load_ack, output, 1, meaning one-cycle pulse when the pending config becomes active.
REQ-011 SHALL provide port tick, output, 1, meaning one-cycle pulse at the start of each output period.
REQ-012 SHALL provide port outclk, output, 1, meaning the divided clock.

Function
REQ-013 SHALL hold count cnt running 0..div_r-1; on reaching div_r-1, cnt SHALL wrap to 0 (the period boundary).
REQ-014 SHALL register outclk, with outclk = (cnt < high_r) driven one cycle after cnt; outclk SHALL be glitch-free and SHALL have no combinational path from inputs.
REQ-015 SHALL assert tick for exactly one cycle, in the same cycle that outclk rises at the period start.
REQ-016 SHALL capture div_val/high_val into pending registers when load=1 on a clk edge; a new load while pending SHALL overwrite the pending values, with only one load_ack issued.
REQ-017 SHALL copy pending into active (div_r, high_r) at the next period boundary when en=1, or on the next cycle when en=0; load_ack SHALL pulse in that same cycle.
REQ-018 SHALL clamp div_val<2 to 2.
REQ-019 SHALL clamp high_val=0 to 1.
REQ-020 SHALL clamp high_val>=N to N-1 (after the N clamp).
REQ-021 SHALL, while en=0, force cnt=0 and outclk=0 and tick=0; after en rises, the first tick/outclk-high SHALL occur exactly 1 cycle later.
REQ-022 SHALL handle simultaneous load and period boundary by applying the old pending value (if any) at that boundary and holding the new value pending until the next boundary.
REQ-023 SHALL treat the maximum divisor 2^WIDTH-1 as legal; cnt SHALL never exceed div_r-1 and SHALL never wrap through 2^WIDTH.

Reset
REQ-024 SHALL, on rst_n=0 at any time (including mid-period or with a load pending), asynchronously set: cnt=0, outclk=0, tick=0, load_ack=0, div_r=DEF_DIV, high_r=DEF_HIGH, pending flag cleared; after release, operation SHALL resume per REQ-021.

Configuration
REQ-025 SHALL support macro CLK_DIV_DUTY50_EN; when defined, it SHALL add input duty50 (1 bit). With duty50=1, high_r SHALL be ignored and outclk SHALL be exactly 50% duty for every N. For even N, the output SHALL be high for N/2 cycles. For odd N, a falling-edge flop SHALL delay the (N-1)/2-cycle high pulse by half a cycle, and the two SHALL be ORed to give (N/2) cycles high. Without the macro, the duty50 port and the falling-edge flop SHALL be absent, and behaviour SHALL be REQ-013..023 only.

Structure
REQ-026 SHALL place constants MIN_DIV=2 and MIN_HIGH=1, and the clamp function for div/high, in shared package clk_div_pkg.
REQ-027 SHALL implement the pending/active registers, clamp logic and load_ack generation in sub-module clk_div_cfg; the counter and output stage SHALL remain in clk_div_prog.

Verification
REQ-028 SHALL verify default operation: reset release, en=1 -> outclk repeats 2 cycles high / 3 low; tick every 5 cycles.
REQ-029 SHALL verify mid-period reconfiguration: load N=4 H=1 at cnt=2 -> old period completes, load_ack at wrap, then 1 high / 3 low.
REQ-030 SHALL verify clamping: load N=0 H=0 -> active N=2 H=1, so outclk toggles every cycle. Separately, N=6 H=9 -> active H=5.
REQ-031 SHALL verify en handling: en=0 for 10 cycles with a load issued -> outclk=0, load_ack on the next cycle; en=1 -> tick 1 cycle later.
REQ-032 SHALL verify reset mid-operation: rst_n low at cnt=3 with load pending -> all outputs 0 immediately; after release, DEF_DIV/DEF_HIGH are in force and no load_ack.
REQ-033 SHALL verify 50% duty with CLK_DIV_DUTY50_EN: duty50=1, N=5 -> high time 2.5 clk periods, period 5; N=4 -> 2/2.
